multiword_addsub: RTL and testbench
===================================

# multiword_addsub

- Word-serial multi-precision adder/subtractor for the CGRA tile.
- Counterpart of the combinational carry-chained `full_adder`: it generates and consumes the carry between words internally, one `width`-bit word per cycle, so a `width*words`-bit operation runs on one narrow datapath.
- Sits between the tile operand router and the tile output register.
- Operands stream in LSW first over a valid/ready handshake; results stream out the same way.

## Interface
Parameters:
- `width`, 8, word width in bits (≥2)
- `words`, 4, words per operation (≥1)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `on_off`  in  1  block enable; 0 freezes all state
- `start`  in  1  begin an operation; sampled only in IDLE
- `sub`  in  1  operation select, sampled with `start`: 0 = a+b, 1 = a−b
- `a`  in  width  operand A word
- `b`  in  width  operand B word
- `in_valid`  in  1  `a`/`b` word valid
- `in_ready`  out  1  word accepted when `in_valid & in_ready`
- `c`  out  width  result word
- `out_valid`  out  1  `c` valid
- `out_ready`  in  1  result consumer ready
- `out_last`  out  1  `c` is the MSW of the operation
- `carry_out`  out  1  final carry (add) or borrow (sub); meaningful only with `out_last`
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN.
- **IDLE**
  - `in_ready`=0.
  - `start & on_off` latches `sub` into `mode`, loads carry register `cy <= sub`, clears word counter `cnt` → RUN.
- **RUN**
  - `in_ready = on_off & (!out_valid | out_ready)`.
  - On each accepted word: `{cy, c} <= a + (mode ? ~b : b) + cy` (width+1-bit sum), `out_valid <= 1`, `cnt <= cnt+1`.
  - On the word where `cnt == words-1`:
    - `out_last <= 1`
    - `carry_out <= mode ? ~carry : carry`
    - `cnt` wraps to 0, → DRAIN.
- **DRAIN**
  - `in_ready`=0.
  - When the last word transfers (`out_valid & out_ready & out_last`): → IDLE, clear `out_valid` and `out_last`.
- **Output register**
  - Clears `out_valid` on transfer unless a new word is accepted in the same cycle.
  - Throughput is one word per cycle with `out_ready` held high.
- **Arithmetic**
  - Unsigned modulo 2^(width·words).
  - Subtraction is two's complement: invert `b`, initial carry 1.
  - Borrow = NOT carry.
- **Boundaries**
  - `start` in RUN or DRAIN is ignored.
  - `in_valid` in IDLE or DRAIN is ignored and no word is consumed.
  - `words`=1: the single accepted word is also the last word.
  - `on_off`=0: no state change. `in_ready`=0. `c`, `out_valid`, `out_last` and `carry_out` hold. `out_ready` is ignored.
  - Reset asserted mid-operation aborts the operation; the partial result is discarded.

## Timing
- Reset values: `in_ready`=0, `c`=0, `out_valid`=0, `out_last`=0, `carry_out`=0, `busy`=0; internal state: FSM=IDLE, `cnt`=0, `cy`=0, `mode`=0.
- `start` accepted at edge N → RUN; `in_ready` can be high in cycle N+1.
- Latency is 1 cycle: a word accepted at edge K gives `c`/`out_valid` after edge K.
- `carry_out` and `out_last` update at the same edge as the MSW `c`.
- Earliest next `start` is the cycle after the last-word transfer, so the minimum operation period is words+2 cycles.
- `in_ready` is combinational from `out_ready`, `out_valid`, state and `on_off`. No other output depends combinationally on any input.

## Configuration
- Macro: `MULTIWORD_ADDSUB_OVF_EN`.
- **Defined**
  - Adds output `ovf` (out, 1): signed two's-complement overflow of the full `width*words` result.
  - `ovf` is computed from the carry into and the carry out of the MSB of the last word.
  - It is valid with `out_last`, resets to 0, and follows the same hold and freeze rules as `carry_out`.
- **Undefined**
  - The `ovf` port and its logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use `width`=8, `words`=4; words are listed LSW first.
- **Add with carry ripple:** `sub`=0, `a`=FF,FF,FF,00, `b`=01,00,00,00 → `c`=00,00,00,01, `out_last` on the 4th word, `carry_out`=0, `ovf`=0.
- **Add overflow:** `a`=FF,FF,FF,FF, `b`=01,00,00,00 → `c`=00,00,00,00, `carry_out`=1. With the macro: `a`=FF,FF,FF,7F, `b`=01,00,00,00 → `c`=00,00,00,80, `ovf`=1.
- **Subtract with borrow:** `sub`=1, `a`=00,00,00,00, `b`=01,00,00,00 → `c`=FF,FF,FF,FF, `carry_out`=1. Then `a`=05,00,00,00, `b`=03,00,00,00 → `c`=02,00,00,00, `carry_out`=0.
- **Backpressure:** `out_ready`=0 for 3 cycles after the 2nd result word → `in_ready`=0, `c` holds the 2nd word for 3 cycles, no word is lost or duplicated, final result unchanged.
- **Freeze:** `on_off`=0 for 5 cycles mid-RUN with `in_valid`=1 and `start` pulsed → no words consumed, outputs held, `start` ignored; the operation completes correctly after `on_off`=1.
- **Reset mid-operation:** `rst_n` low after the 2nd word is accepted → all outputs 0 immediately. A new `start` afterwards runs a full 4-word add correctly.

Source files
------------

// File: rtl/multiword_addsub.sv
// Word-serial multi-precision adder/subtractor: one width-bit word per cycle, LSW first,
// carry chained internally between words. Define MULTIWORD_ADDSUB_OVF_EN to add the ovf output.
module multiword_addsub #(
    parameter int width = 8,
    parameter int words = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             on_off,
    input  logic             start,
    input  logic             sub,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [width-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             carry_out,
`ifdef MULTIWORD_ADDSUB_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int CW = (words > 1) ? $clog2(words) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(words - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             mode_q, mode_d;
    logic [width-1:0] c_q, c_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             carry_out_q, carry_out_d;
`ifdef MULTIWORD_ADDSUB_OVF_EN
    logic             ovf_q, ovf_d;
    logic             msb_cin;
`endif

    logic [width-1:0] b_eff;
    logic [width:0]   sum;
    logic             accept;
    logic             xfer;

    // Handshake: valid/ready, a word moves on any cycle where both are high; on_off=0 blocks both sides.
    assign in_ready = on_off && (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = on_off && out_valid_q && out_ready;

    always_comb begin
        b_eff = mode_q ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{width{1'b0}}, cy_q};
    end

`ifdef MULTIWORD_ADDSUB_OVF_EN
    // Carry into the MSB recovered from the sum bit; overflow when it differs from carry out.
    assign msb_cin = a[width-1] ^ b_eff[width-1] ^ sum[width-1];
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cy_d        = cy_q;
        mode_d      = mode_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        carry_out_d = carry_out_q;
`ifdef MULTIWORD_ADDSUB_OVF_EN
        ovf_d       = ovf_q;
`endif
        if (on_off) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_d  = sub;
                        cy_d    = sub;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (xfer) out_valid_d = 1'b0;
                    if (accept) begin
                        c_d         = sum[width-1:0];
                        cy_d        = sum[width];
                        out_valid_d = 1'b1;
                        cnt_d       = cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            out_last_d  = 1'b1;
                            carry_out_d = mode_q ? ~sum[width] : sum[width];
`ifdef MULTIWORD_ADDSUB_OVF_EN
                            ovf_d       = msb_cin ^ sum[width];
`endif
                            cnt_d       = '0;
                            state_d     = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer && out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cy_q        <= 1'b0;
            mode_q      <= 1'b0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            carry_out_q <= 1'b0;
`ifdef MULTIWORD_ADDSUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cy_q        <= cy_d;
            mode_q      <= mode_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            carry_out_q <= carry_out_d;
`ifdef MULTIWORD_ADDSUB_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign c         = c_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign carry_out = carry_out_q;
    assign busy      = (state_q != IDLE);
`ifdef MULTIWORD_ADDSUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_multiword_addsub.sv
// Scoreboard bench for multiword_addsub: expected words come from a whole-operand
// arithmetic model; a negedge monitor pops and compares every output transfer.
module tb_multiword_addsub;

    localparam int W  = 8;
    localparam int NW = 4;
    localparam int N  = W * NW;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         on_off = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic [W-1:0] c;
    logic         out_valid;
    logic         out_last;
    logic         carry_out;
    logic         busy;
`ifdef MULTIWORD_ADDSUB_OVF_EN
    logic         ovf;
`endif

    multiword_addsub #(.width(W), .words(NW)) dut (
        .clk(clk), .rst_n(rst_n), .on_off(on_off), .start(start), .sub(sub),
        .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
        .c(c), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .carry_out(carry_out),
`ifdef MULTIWORD_ADDSUB_OVF_EN
        .ovf(ovf),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] c;
        logic         last;
        logic         cy;
        logic         ov;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   in_seen = 0;
    int   out_seen = 0;
    bit   rand_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns {ovf, carry_or_borrow, result} for the full N-bit operation.
    function automatic logic [N+1:0] model(input logic s, input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N:0] full;
        logic       cy;
        logic       ov;
        full = s ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        cy   = s ? (x < y) : full[N];
        ov   = s ? ((x[N-1] != y[N-1]) && (full[N-1] != x[N-1]))
                 : ((x[N-1] == y[N-1]) && (full[N-1] != x[N-1]));
        return {ov, cy, full[N-1:0]};
    endfunction

    // Monitor
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && on_off && out_valid && out_ready) begin
                out_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got c=%0h expected no word", c);
                end else begin
                    e = exp_q.pop_front();
                    check("c", c, e.c);
                    check("out_last", out_last, e.last);
                    if (e.last) begin
                        check("carry_out", carry_out, e.cy);
`ifdef MULTIWORD_ADDSUB_OVF_EN
                        check("ovf", ovf, e.ov);
`endif
                    end
                end
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_c"}, c, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_carry_out"}, carry_out, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 0);
`ifdef MULTIWORD_ADDSUB_OVF_EN
        check({tag, "_ovf"}, ovf, 0);
`endif
    endtask

    // Driver: one full operation; abort_at>0 pulls reset right after that many words are accepted.
    task automatic do_op(input logic s, input logic [N-1:0] x, input logic [N-1:0] y, input int abort_at);
        logic [N+1:0] m;
        logic [N-1:0] r;
        exp_t         e;
        int           t;
        m = model(s, x, y);
        r = m[N-1:0];
        for (int i = 0; i < NW; i++) begin
            e.c    = r[i*W +: W];
            e.last = (i == NW - 1);
            e.cy   = m[N];
            e.ov   = m[N+1];
            exp_q.push_back(e);
        end
        in_seen  = 0;
        out_seen = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        sub   = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        sub   = 1'($urandom_range(0, 1));
        for (int i = 0; i < NW; i++) begin
            a        = x[i*W +: W];
            b        = y[i*W +: W];
            in_valid = 1'b1;
            t        = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                t++;
                if (t > 300) break;
            end
            if (t > 300) begin
                check("in_ready_timeout", 0, 1);
                break;
            end
            in_seen++;
            @(posedge clk);
            #1;
            if (in_seen == abort_at) begin
                rst_n    = 1'b0;
                in_valid = 1'b0;
                #1;
                check_reset_outputs("abort");
                exp_q.delete();
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
        end
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        t        = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            t++;
            if (t > 300) break;
        end
        if (t > 300) check("drain_timeout", 0, 1);
    endtask

    task automatic backpressure_proc(input logic [N-1:0] r);
        int t = 0;
        while (!(out_valid && out_seen == 1) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 300) check("bp_wait_timeout", 0, 1);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_c_hold", c, r[W +: W]);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    task automatic freeze_proc();
        logic [W-1:0] hc;
        logic         hv;
        logic         hb;
        int           t = 0;
        while (in_seen < 2 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 300) check("frz_wait_timeout", 0, 1);
        on_off = 1'b0;
        start  = 1'b1;
        hc = c;
        hv = out_valid;
        hb = busy;
        repeat (5) begin
            @(negedge clk);
            check("frz_in_ready", in_ready, 0);
            check("frz_c", c, hc);
            check("frz_out_valid", out_valid, hv);
            check("frz_busy", busy, hb);
            check("frz_words_taken", in_seen, 2);
        end
        @(posedge clk);
        #1;
        on_off = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin : main
        logic [N+1:0] m;
        logic [N-1:0] x;
        logic [N-1:0] y;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", busy, 0);

        in_valid = 1'b1;
        a        = 8'h55;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("idle_no_output", out_valid, 0);

        do_op(1'b0, 32'h00FF_FFFF, 32'h0000_0001, 0);
        do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        do_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        do_op(1'b1, 32'h0000_0000, 32'h0000_0001, 0);
        do_op(1'b1, 32'h0000_0005, 32'h0000_0003, 0);

        x = $urandom;
        y = $urandom;
        m = model(1'b0, x, y);
        fork
            do_op(1'b0, x, y, 0);
            backpressure_proc(m[N-1:0]);
        join

        fork
            do_op(1'b1, $urandom, $urandom, 0);
            freeze_proc();
        join

        do_op(1'b0, $urandom, $urandom, 2);
        do_op(1'b0, 32'h00FF_FFFF, 32'h0000_0001, 0);

        rand_rdy = 1'b1;
        repeat (40) do_op(1'($urandom_range(0, 1)), $urandom, $urandom, 0);
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
